icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_if.sv | 23 ++
 rtl/icache.sv | 140 ++++++++++++++
 tb/tb_icache.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetch-side and memory-control-side signals of the instruction cache.
// Latency/backpressure: wires only; the requester holds a fetch until fetch_rdy.
interface icache_if;
  logic        fetch_en;
  logic [31:0] fetch_addr;
  logic        fetch_rdy;
  logic [31:0] fetch_inst;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic        mem_rdy;
  logic [31:0] mem_data;

  // master: decoder plus memory control; slave: the cache itself
  modport master (
    output fetch_en, fetch_addr, mem_rdy, mem_data,
    input  fetch_rdy, fetch_inst, mem_en, mem_addr
  );

  modport slave (
    input  fetch_en, fetch_addr, mem_rdy, mem_data,
    output fetch_rdy, fetch_inst, mem_en, mem_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache; storage only with ICACHE_EN, else every fetch misses.
// Latency: hit 1 cycle; miss returns the cycle after mem_rdy. Responses are single-cycle fetch_rdy pulses.
// Backpressure: rdy_in low freezes everything; mem_en is held until mem_rdy.
module icache #(
  parameter int INDEX_WIDTH = 4
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  input  logic      flush,
  icache_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HIT_RESP  = 2'd1,
    MISS_WAIT = 2'd2,
    MISS_RESP = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        fetch_rdy_q, fetch_rdy_nxt;
  logic [31:0] fetch_inst_q, fetch_inst_nxt;
  logic        mem_en_q, mem_en_nxt;
  logic [31:0] mem_addr_q, mem_addr_nxt;
  logic        fill_we;
  logic        hit;
  logic [31:0] hit_dat;
  logic [31:0] word_addr;

  assign word_addr = bus.fetch_addr & ~32'h3;

`ifdef ICACHE_EN
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 30 - INDEX_WIDTH;

  logic [LINES-1:0]       line_vld;
  logic [TAG_W-1:0]       line_tag [LINES];
  logic [31:0]            line_dat [LINES];
  logic [INDEX_WIDTH-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0]       rd_tag, wr_tag;

  assign rd_idx  = bus.fetch_addr[1+INDEX_WIDTH:2];
  assign rd_tag  = bus.fetch_addr[31:2+INDEX_WIDTH];
  assign hit     = line_vld[rd_idx] && (line_tag[rd_idx] == rd_tag);
  assign hit_dat = line_dat[rd_idx];

  // Fill uses the latched miss address so the line written is the one requested.
  assign wr_idx = mem_addr_q[1+INDEX_WIDTH:2];
  assign wr_tag = mem_addr_q[31:2+INDEX_WIDTH];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      line_vld <= '0;
    end else if (fill_we) begin
      line_vld[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && fill_we) begin
      line_tag[wr_idx] <= wr_tag;
      line_dat[wr_idx] <= bus.mem_data;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_dat = 32'h0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      fetch_rdy_q  <= 1'b0;
      fetch_inst_q <= 32'h0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
    end else begin
      state        <= state_nxt;
      fetch_rdy_q  <= fetch_rdy_nxt;
      fetch_inst_q <= fetch_inst_nxt;
      mem_en_q     <= mem_en_nxt;
      mem_addr_q   <= mem_addr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    fetch_rdy_nxt  = fetch_rdy_q;
    fetch_inst_nxt = fetch_inst_q;
    mem_en_nxt     = mem_en_q;
    mem_addr_nxt   = mem_addr_q;
    fill_we        = 1'b0;
    if (rdy_in) begin
      fetch_rdy_nxt = 1'b0;
      if (flush) begin
        // A same-edge mem_rdy is dropped: no fill, no response.
        state_nxt  = IDLE;
        mem_en_nxt = 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.fetch_en) begin
              if (hit) begin
                state_nxt      = HIT_RESP;
                fetch_rdy_nxt  = 1'b1;
                fetch_inst_nxt = hit_dat;
              end else begin
                state_nxt    = MISS_WAIT;
                mem_en_nxt   = 1'b1;
                mem_addr_nxt = word_addr;
              end
            end
          end
          MISS_WAIT: begin
            if (bus.mem_rdy) begin
              state_nxt      = MISS_RESP;
              mem_en_nxt     = 1'b0;
              fill_we        = 1'b1;
              fetch_inst_nxt = bus.mem_data;
              fetch_rdy_nxt  = 1'b1;
            end
          end
          HIT_RESP, MISS_RESP: begin
            state_nxt = IDLE;
          end
          default: begin
            state_nxt = IDLE;
          end
        endcase
      end
    end
  end

  assign bus.fetch_rdy  = fetch_rdy_q;
  assign bus.fetch_inst = fetch_inst_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Scoreboarded bench for icache: the bench plays decoder and memory control.
module tb_icache;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b0;
  logic flush  = 1'b0;

  icache_if bus ();

  icache #(.INDEX_WIDTH(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Response monitor: every fetch_rdy pulse consumes one expected word.
  always @(negedge clk_in) begin
    if (!rst_in && bus.fetch_rdy === 1'b1) begin
      if (sb.size() == 0) check("unexpected_rdy", 32'(bus.fetch_rdy), 32'd0);
      else check("fetch_inst", bus.fetch_inst, sb.pop_front());
    end
  end

  // Called at posedge+1 with the cache idle; memory answers on the second mem_en cycle.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                          input bit exp_hit, input int stall);
    int cyc = -1;
    int mem_cnt = 0;
    int rdy_cyc = -1;
    bit saw_mem = 1'b0;
    bit hit_eff;
    int exp_lat;
    logic [31:0] inst_hold;
`ifdef ICACHE_EN
    hit_eff = exp_hit;
`else
    hit_eff = 1'b0;
`endif
    exp_lat = hit_eff ? 1 : 3 + stall;
    bus.fetch_en   = 1'b1;
    bus.fetch_addr = addr;
    sb.push_back(data);
    inst_hold = bus.fetch_inst;
    while (rdy_cyc < 0 && cyc < 40) begin
      @(negedge clk_in);
      cyc++;
      if (bus.mem_rdy) begin
        bus.mem_rdy = 1'b0;
        check("cooldown_mem_en", 32'(bus.mem_en), 32'd0);
      end else if (bus.mem_en) begin
        saw_mem = 1'b1;
        mem_cnt++;
        check("mem_addr", bus.mem_addr, addr & ~32'h3);
        if (mem_cnt == 1 && stall > 0) begin
          rdy_in = 1'b0;
          repeat (stall) begin
            @(negedge clk_in);
            cyc++;
            check("stall_mem_en", 32'(bus.mem_en), 32'd1);
            check("stall_mem_addr", bus.mem_addr, addr & ~32'h3);
            check("stall_fetch_rdy", 32'(bus.fetch_rdy), 32'd0);
            check("stall_fetch_inst", bus.fetch_inst, inst_hold);
          end
          rdy_in = 1'b1;
        end else if (mem_cnt == 2) begin
          bus.mem_rdy  = 1'b1;
          bus.mem_data = data;
        end
      end
      if (bus.fetch_rdy) rdy_cyc = cyc;
    end
    bus.mem_rdy = 1'b0;
    check("latency", 32'(rdy_cyc), 32'(exp_lat));
    check("mem_en_used", 32'(saw_mem), 32'(!hit_eff));
    @(posedge clk_in); #1;
    bus.fetch_en   = 1'b0;
    bus.fetch_addr = $urandom;
    @(negedge clk_in);
    check("rdy_single_pulse", 32'(bus.fetch_rdy), 32'd0);
    check("post_resp_mem_en", 32'(bus.mem_en), 32'd0);
    check("inst_hold", bus.fetch_inst, data);
    @(posedge clk_in); #1;
  endtask

  task automatic wait_mem_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk_in);
      if (bus.mem_en) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    bus.fetch_en   = 1'b0;
    bus.fetch_addr = 32'h0;
    bus.mem_rdy    = 1'b0;
    bus.mem_data   = 32'h0;

    // Reset with rdy_in low: reset must still act.
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_fetch_rdy", 32'(bus.fetch_rdy), 32'd0);
    check("rst_fetch_inst", bus.fetch_inst, 32'h0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    rst_in = 1'b0;
    rdy_in = 1'b1;
    @(posedge clk_in); #1;

    do_fetch(32'h0000_1000, 32'h0050_0093, 1'b0, 0);
    do_fetch(32'h0000_1000, 32'h0050_0093, 1'b1, 0);

    // Same index, different tag: eviction by overwrite, then refill.
    do_fetch(32'h0000_1040, 32'hAABB_CCDD, 1'b0, 0);
    do_fetch(32'h0000_1000, 32'h0050_0093, 1'b0, 0);
    do_fetch(32'h0000_1000, 32'h0050_0093, 1'b1, 0);

    // Flush in MISS_WAIT with mem_rdy on the same edge.
    bus.fetch_en   = 1'b1;
    bus.fetch_addr = 32'h0000_2000;
    wait_mem_en(ok);
    check("flush_mem_en_seen", 32'(ok), 32'd1);
    check("flush_mem_addr", bus.mem_addr, 32'h0000_2000);
    flush        = 1'b1;
    bus.mem_rdy  = 1'b1;
    bus.mem_data = 32'hBAD0_BAD0;
    @(negedge clk_in);
    flush        = 1'b0;
    bus.mem_rdy  = 1'b0;
    bus.fetch_en = 1'b0;
    check("flush_fetch_rdy", 32'(bus.fetch_rdy), 32'd0);
    check("flush_mem_en", 32'(bus.mem_en), 32'd0);
    @(negedge clk_in);
    check("flush_no_late_rdy", 32'(bus.fetch_rdy), 32'd0);
    check("flush_no_mem_en", 32'(bus.mem_en), 32'd0);
    @(posedge clk_in); #1;
    do_fetch(32'h0000_2000, 32'hDEAD_0001, 1'b0, 0);
    do_fetch(32'h0000_2000, 32'hDEAD_0001, 1'b1, 0);
    do_fetch(32'h0000_2002, 32'hDEAD_0001, 1'b1, 0);

    // rdy_in low for 3 cycles while waiting on memory.
    do_fetch(32'h0000_3004, 32'h0000_3003, 1'b0, 3);
    do_fetch(32'h0000_3007, 32'h0000_3003, 1'b1, 0);

    // Reset mid-miss, with a coincident mem_rdy that must be ignored.
    bus.fetch_en   = 1'b1;
    bus.fetch_addr = 32'h0000_4008;
    wait_mem_en(ok);
    check("rst_mid_mem_en_seen", 32'(ok), 32'd1);
    rst_in       = 1'b1;
    bus.mem_rdy  = 1'b1;
    bus.mem_data = 32'h1234_5678;
    @(negedge clk_in);
    rst_in       = 1'b0;
    bus.mem_rdy  = 1'b0;
    bus.fetch_en = 1'b0;
    check("rst_mid_fetch_rdy", 32'(bus.fetch_rdy), 32'd0);
    check("rst_mid_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mid_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mid_fetch_inst", bus.fetch_inst, 32'h0);
    @(posedge clk_in); #1;
    do_fetch(32'h0000_1000, 32'h0050_0093, 1'b0, 0);
    do_fetch(32'h0000_4008, 32'h4444_0008, 1'b0, 0);
    do_fetch(32'h0000_1000, 32'h0050_0093, 1'b1, 0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
